xxd_unhex: RTL and testbench
============================

# xxd_unhex

Reverse hex-dump decoder, the `xxd -r -p` direction of the xxd byte pipeline. It consumes an ASCII hex character stream on the dedicated inputs, pairs hex digits into bytes, skips whitespace and flags illegal characters. Decoded bytes are buffered in a 4-entry FIFO and presented on the dedicated outputs with a valid/ready handshake. It sits at the tile's top level and uses the standard Tiny Tapeout pin set.

## Interface
- `DEPTH`, 4: output FIFO entries; power of two, at least 2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  always 1; unused.
- `ui_in`  in  8  ASCII input character.
- `uio_in[0]`  in  1  `in_valid`: character on `ui_in` is offered this cycle.
- `uio_in[1]`  in  1  `out_ready`: sink accepts the FIFO head this cycle.
- `uio_in[2]`  in  1  `clr_err`: synchronous clear of the error flag.
- `uio_in[7:3]`  in  5  unused.
- `uo_out`  out  8  decoded byte at the FIFO head; 8'h00 when the FIFO is empty.
- `uio_out[3]`  out  1  `in_ready`: FIFO not full.
- `uio_out[4]`  out  1  `out_valid`: FIFO not empty.
- `uio_out[5]`  out  1  `err`: sticky illegal-character flag.
- `uio_out[6]`  out  1  `pending`: high nibble held, waiting for the low nibble.
- `uio_out[2:0]`, `uio_out[7]`  out  4  constant 0.
- `uio_oe`  out  8  constant 8'b0111_1000.

## Operation
- A character is accepted on a rising edge when `in_valid && in_ready`. A character offered while `in_ready=0` is not consumed; the source holds it.
- Character classes:
  - Hex: 0x30–0x39, 0x41–0x46, 0x61–0x66, mapping to nibble 0–15; case-insensitive.
  - Whitespace: 0x20, 0x09, 0x0A, 0x0D.
  - Illegal: everything else.
- State machine with two states, HI (reset state) and LO.
  - HI + hex: latch the nibble as the high nibble and go to LO.
  - LO + hex: push `{hi, nibble}` into the FIFO and go to HI.
  - Whitespace: ignored in both states; no state change. A nibble pair may straddle whitespace.
  - Illegal in HI: set `err`; stay in HI.
  - Illegal in LO: set `err`; discard the held nibble; go to HI.
- `pending` = (state == LO).
- `in_ready` = count < DEPTH, for every character class. This keeps backpressure simple.
- Pop on `out_valid && out_ready`.
- Push and pop in the same cycle: count unchanged, data order preserved.
- `clr_err` clears `err` on the next edge. An illegal character accepted in the same cycle wins, so `err` stays 1.
- Count width is clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.

## Timing
- Reset values: state HI, FIFO empty, `err=0`, `uo_out=0x00`, `out_valid=0`, `in_ready=1`, `pending=0`.
- Reset is asynchronous and may assert mid-operation. The held nibble and all FIFO contents are discarded immediately.
- Latency from accepting the low-nibble character at edge N:
  - `out_valid=1` and `uo_out` = byte after edge N (1 cycle).
  - Same-cycle bypass from `ui_in` to `uo_out` is not permitted.
- `in_ready` and `out_valid` are functions of registered count only; no combinational path from `uio_in` reaches them.
- Throughput: one character per cycle, so one byte every 2 cycles, sustained while the sink keeps `out_ready=1`.
- FIFO full with `out_ready=1`: `in_ready` stays 0 that cycle and returns to 1 the cycle after the pop.

## Structure
- Package `xxd_pkg` holds:
  - Pin index constants for `in_valid`, `out_ready`, `clr_err`, `in_ready`, `out_valid`, `err`, `pending`.
  - Whitespace character constants.
  - State enum {HI, LO}.
  - Function `hex_nibble(char) -> {is_hex, is_ws, nibble[3:0]}`.
- Sub-module `xxd_byte_fifo`: parameterized `DEPTH`×8 synchronous FIFO with push, pop, head, empty, full, count, and async active-low reset.
- The top level holds the decode FSM, the held-nibble register, the `err` flag and the pin mapping.

## Test plan
- Reset, then "4", "1" with `out_ready=1` → `out_valid` one cycle after "1" is accepted, `uo_out=0x41`; FIFO empty again after the pop.
- "d","E"," ","a","\n","F" with `out_ready=1` → bytes 0xDE then 0xAF; `pending` high after "d" and after "a"; `err=0`.
- "3","g","7","7" → `err=1`, the "3" is discarded, one byte 0x77 out. Assert `clr_err` → `err=0` next cycle.
- `out_ready=0`, stream "0102030405" → 4 bytes buffered, `in_ready=0` after the 4th push; "05" held. Raise `out_ready` → outputs 01,02,03,04,05 in order with no loss.
- Assert `rst_n` low while `pending=1` and FIFO holds 2 bytes → all outputs return to reset values asynchronously; the next "AB" yields exactly 0xAB.
- Illegal character and `clr_err` in the same cycle → `err` remains 1.

Source files
------------

// File: rtl/xxd_pkg.sv
// xxd_pkg: shared definitions for the xxd reverse hex-dump decoder.
//   - pin index constants for the Tiny Tapeout uio_in / uio_out buses
//   - whitespace character constants
//   - decode state enum
//   - hex_nibble(): classifies one ASCII character and yields its nibble value
package xxd_pkg;

  // uio_in bit positions
  localparam int IDX_IN_VALID  = 0;
  localparam int IDX_OUT_READY = 1;
  localparam int IDX_CLR_ERR   = 2;

  // uio_out bit positions
  localparam int IDX_IN_READY  = 3;
  localparam int IDX_OUT_VALID = 4;
  localparam int IDX_ERR       = 5;
  localparam int IDX_PENDING   = 6;

  // Characters that are silently skipped
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  // HI: waiting for the high nibble; LO: high nibble held, waiting for the low one
  typedef enum logic {
    HI = 1'b0,
    LO = 1'b1
  } state_e;

  typedef struct packed {
    logic       is_hex;
    logic       is_ws;
    logic [3:0] nibble;
  } hex_class_t;

  // Classify a character. Letters A-F / a-f share the low bits 1..6, so adding
  // 9 maps them onto 10..15 regardless of case.
  function automatic hex_class_t hex_nibble(input logic [7:0] ch);
    hex_class_t res;
    res.is_hex = 1'b0;
    res.is_ws  = 1'b0;
    res.nibble = 4'h0;
    if ((ch >= 8'h30) && (ch <= 8'h39)) begin
      res.is_hex = 1'b1;
      res.nibble = ch[3:0];
    end else if (((ch >= 8'h41) && (ch <= 8'h46)) || ((ch >= 8'h61) && (ch <= 8'h66))) begin
      res.is_hex = 1'b1;
      res.nibble = ch[3:0] + 4'd9;
    end else if ((ch == CH_SPACE) || (ch == CH_TAB) || (ch == CH_LF) || (ch == CH_CR)) begin
      res.is_ws = 1'b1;
    end else begin
      res.is_ws = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/xxd_byte_fifo.sv
// xxd_byte_fifo: DEPTH x 8 synchronous FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write din when push && !full
//   pop        : drop the head when pop && !empty
//   head       : current head byte, 8'h00 while empty
//   empty/full : occupancy flags, count : number of stored bytes
// DEPTH must be a power of two so the pointers wrap naturally.
module xxd_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty     = (count_r == CW'(0));
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  // Masking with empty hides stale storage after reset or a drain
  assign head      = empty ? 8'h00 : mem_r[rd_ptr_r];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write; contents need no reset because head is masked while empty
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/xxd_unhex.sv
// xxd_unhex: ASCII hex stream to byte decoder (xxd -r -p), Tiny Tapeout pinout.
//   ui_in        : ASCII character offered when uio_in[0] (in_valid) is high
//   uio_in[1]    : out_ready, uio_in[2] : clr_err
//   uo_out       : FIFO head byte (8'h00 when empty)
//   uio_out[3:6] : in_ready, out_valid, err, pending; other bits 0
//   uio_oe       : constant 8'b0111_1000
// Holds the two-state nibble-pairing FSM, the held nibble and the sticky error.
module xxd_unhex
  import xxd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e        state_r;
  logic [3:0]    hi_r;
  logic          err_r;

  hex_class_t    cls_s;
  logic          in_valid_s;
  logic          out_ready_s;
  logic          clr_err_s;
  logic          in_ready_s;
  logic          accept_s;
  logic          illegal_s;
  logic          push_s;
  logic          pop_s;
  logic [7:0]    head_s;
  logic          empty_s;
  logic          full_s;
  logic [CW-1:0] count_s;
  logic [7:0]    uio_out_s;
  logic          unused_s;

  assign in_valid_s  = uio_in[IDX_IN_VALID];
  assign out_ready_s = uio_in[IDX_OUT_READY];
  assign clr_err_s   = uio_in[IDX_CLR_ERR];

  assign cls_s       = hex_nibble(ui_in);
  // Backpressure depends only on the registered count, for every character class
  assign in_ready_s  = (count_s < CW'(DEPTH));
  assign accept_s    = in_valid_s && in_ready_s;
  assign illegal_s   = accept_s && !cls_s.is_hex && !cls_s.is_ws;
  assign push_s      = accept_s && cls_s.is_hex && (state_r == LO);
  assign pop_s       = out_ready_s && !empty_s;

  xxd_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   ({hi_r, cls_s.nibble}),
    .pop   (pop_s),
    .head  (head_s),
    .empty (empty_s),
    .full  (full_s),
    .count (count_s)
  );

  // Nibble-pairing FSM, held high nibble and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= HI;
      hi_r    <= 4'h0;
      err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        if (cls_s.is_hex) begin
          case (state_r)
            HI: begin
              hi_r    <= cls_s.nibble;
              state_r <= LO;
            end
            LO:      state_r <= HI;
            default: state_r <= HI;
          endcase
        end else if (cls_s.is_ws) begin
          state_r <= state_r;
        end else begin
          // Illegal character drops any half-built byte
          state_r <= HI;
        end
      end
      // A new illegal character takes priority over a clear request
      if (illegal_s) begin
        err_r <= 1'b1;
      end else if (clr_err_s) begin
        err_r <= 1'b0;
      end
    end
  end

  // Status pin mapping
  always_comb begin
    uio_out_s                = 8'h00;
    uio_out_s[IDX_IN_READY]  = in_ready_s;
    uio_out_s[IDX_OUT_VALID] = !empty_s;
    uio_out_s[IDX_ERR]       = err_r;
    uio_out_s[IDX_PENDING]   = (state_r == LO);
  end

  assign uo_out   = head_s;
  assign uio_out  = uio_out_s;
  assign uio_oe   = 8'b0111_1000;
  assign unused_s = &{1'b0, ena, uio_in[7:3], full_s};

endmodule

// File: tb/tb_xxd_unhex.sv
// tb_xxd_unhex: randomized and directed self-checking bench for xxd_unhex.
// A queue-based reference model follows the decoding rules character by character.
module tb_xxd_unhex;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] model_q[$];
  logic       m_pending;
  logic [3:0] m_hi;
  logic       m_err;
  logic       last_acc;

  logic [11:0] obs;
  logic [11:0] exp_v;

  always #5 clk = ~clk;

  xxd_unhex #(.DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Hex digit value by table lookup after folding upper case to lower; -1 if not hex
  function automatic int ref_digit(input logic [7:0] c);
    string      digs;
    logic [7:0] lc;
    digs = "0123456789abcdef";
    lc = ((c >= 8'h41) && (c <= 8'h5A)) ? (c + 8'h20) : c;
    for (int i = 0; i < 16; i++) begin
      if (digs[i] == lc) return i;
    end
    return -1;
  endfunction

  function automatic logic ref_is_ws(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
  endfunction

  // Expected {uo_out, pending, err, out_valid, in_ready}
  function automatic logic [11:0] model_out();
    logic [7:0] hd;
    hd = (model_q.size() > 0) ? model_q[0] : 8'h00;
    return {hd, m_pending, m_err, (model_q.size() > 0), (model_q.size() < 4)};
  endfunction

  task automatic model_reset();
    model_q.delete();
    m_pending = 1'b0;
    m_hi      = 4'h0;
    m_err     = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the clock, update the model
  task automatic drive(input logic v, input logic [7:0] ch, input logic rdy, input logic clr);
    int   d;
    logic pop;
    logic bad;
    ui_in  = ch;
    uio_in = {5'b00000, clr, rdy, v};
    last_acc = v && (model_q.size() < 4);
    pop = rdy && (model_q.size() > 0);
    d = ref_digit(ch);
    bad = last_acc && (d < 0) && !ref_is_ws(ch);
    @(posedge clk);
    #1;
    if (pop) void'(model_q.pop_front());
    if (last_acc && (d >= 0)) begin
      if (m_pending) begin
        model_q.push_back({m_hi, 4'(d)});
        m_pending = 1'b0;
      end else begin
        m_hi      = 4'(d);
        m_pending = 1'b1;
      end
    end
    if (bad) begin
      m_err     = 1'b1;
      m_pending = 1'b0;
    end else if (clr) begin
      m_err = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out got %h exp 00", uo_out); end
    checks++;
    if (uio_out !== 8'h08) begin errors++; $display("FAIL reset_uio_out got %h exp 08", uio_out); end
    checks++;
    if (uio_oe !== 8'h78) begin errors++; $display("FAIL uio_oe got %h exp 78", uio_oe); end
  endtask

  task automatic test_basic();
    drive(1'b1, 8'h34, 1'b1, 1'b0);
    checks++;
    if (uio_out[6] !== 1'b1 || uio_out[4] !== 1'b0) begin
      errors++; $display("FAIL basic_after_4 got pend=%b valid=%b exp 1 0", uio_out[6], uio_out[4]);
    end
    drive(1'b1, 8'h31, 1'b1, 1'b0);
    checks++;
    if (uo_out !== 8'h41 || uio_out[4] !== 1'b1) begin
      errors++; $display("FAIL basic_byte got %h valid=%b exp 41 1", uo_out, uio_out[4]);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (uio_out[4] !== 1'b0 || uo_out !== 8'h00) begin
      errors++; $display("FAIL basic_drain got valid=%b uo=%h exp 0 00", uio_out[4], uo_out);
    end
  endtask

  task automatic test_whitespace();
    string      s;
    logic [7:0] got[$];
    s = "dE a\nF";
    for (int i = 0; i < s.len(); i++) begin
      if (uio_out[4]) got.push_back(uo_out);
      drive(1'b1, s[i], 1'b1, 1'b0);
      obs = {uo_out, uio_out[6:3]};
      exp_v = model_out();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL ws_step%0d got %h exp %h", i, obs, exp_v); end
      if ((i == 0 || i == 3) && uio_out[6] !== 1'b1) begin
        errors++; $display("FAIL ws_pending%0d got 0 exp 1", i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (uio_out[4]) got.push_back(uo_out);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++;
    if (got.size() != 2 || got[0] !== 8'hDE || got[1] !== 8'hAF || uio_out[5] !== 1'b0) begin
      errors++; $display("FAIL ws_bytes got n=%0d err=%b exp n=2 DE AF err=0", got.size(), uio_out[5]);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    drive(1'b1, 8'h67, 1'b1, 1'b0);
    checks++;
    if (uio_out[5] !== 1'b1 || uio_out[6] !== 1'b0) begin
      errors++; $display("FAIL illegal_flag got err=%b pend=%b exp 1 0", uio_out[5], uio_out[6]);
    end
    drive(1'b1, 8'h37, 1'b1, 1'b0);
    drive(1'b1, 8'h37, 1'b1, 1'b0);
    checks++;
    if (uo_out !== 8'h77) begin errors++; $display("FAIL illegal_byte got %h exp 77", uo_out); end
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (uio_out[5] !== 1'b0 || uio_out[4] !== 1'b0) begin
      errors++; $display("FAIL clr_err got err=%b valid=%b exp 0 0", uio_out[5], uio_out[4]);
    end
    // Illegal character accepted together with clr_err: error must survive
    drive(1'b1, 8'h7A, 1'b0, 1'b1);
    checks++;
    if (uio_out[5] !== 1'b1) begin errors++; $display("FAIL err_vs_clr got 0 exp 1"); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    string      s;
    int         idx;
    logic [7:0] got[$];
    s = "0102030405";
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, s[idx], 1'b0, 1'b0);
      if (last_acc) idx++;
    end
    checks++;
    if (uio_out[3] !== 1'b0 || uio_out[4] !== 1'b1 || idx != 8) begin
      errors++; $display("FAIL bp_full got in_ready=%b valid=%b idx=%0d exp 0 1 8", uio_out[3], uio_out[4], idx);
    end
    for (int c = 0; c < 20; c++) begin
      if (uio_out[4]) got.push_back(uo_out);
      drive(idx < 10, (idx < 10) ? s[idx] : 8'h20, 1'b1, 1'b0);
      if (last_acc && idx < 10) idx++;
      obs = {uo_out, uio_out[6:3]};
      exp_v = model_out();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL bp_drain%0d got %h exp %h", c, obs, exp_v); end
    end
    checks++;
    if (got.size() != 5) begin
      errors++; $display("FAIL bp_count got %0d exp 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== 8'(i + 1)) begin errors++; $display("FAIL bp_order%0d got %h exp %h", i, got[i], 8'(i + 1)); end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'h30, 1'b0, 1'b0);
    drive(1'b1, 8'h31, 1'b0, 1'b0);
    drive(1'b1, 8'h30, 1'b0, 1'b0);
    drive(1'b1, 8'h32, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    uio_in = 8'h00;
    checks++;
    if (uio_out[6] !== 1'b1 || uo_out !== 8'h01) begin
      errors++; $display("FAIL pre_reset got pend=%b uo=%h exp 1 01", uio_out[6], uo_out);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h08) begin
      errors++; $display("FAIL async_reset got uo=%h uio=%h exp 00 08", uo_out, uio_out);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive(1'b1, 8'h41, 1'b1, 1'b0);
    drive(1'b1, 8'h42, 1'b1, 1'b0);
    checks++;
    if (uo_out !== 8'hAB || uio_out[4] !== 1'b1) begin
      errors++; $display("FAIL post_reset_byte got %h exp AB", uo_out);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (uio_out[4] !== 1'b0) begin errors++; $display("FAIL post_reset_empty got 1 exp 0"); end
  endtask

  task automatic test_random();
    string      hexs;
    string      wss;
    logic [7:0] ch;
    int         sel;
    hexs = "0123456789abcdefABCDEF";
    wss  = " \t\n\r";
    for (int c = 0; c < 400; c++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1, 2: ch = hexs[$urandom_range(0, 21)];
        3:       ch = wss[$urandom_range(0, 3)];
        default: ch = 8'($urandom_range(0, 255));
      endcase
      drive($urandom_range(0, 3) != 0, ch, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
      obs = {uo_out, uio_out[6:3]};
      exp_v = model_out();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random%0d got %h exp %h", c, obs, exp_v); end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();
    #12 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_whitespace();
    test_illegal();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
